// File: rtl/cnt_time_pkg.sv
// Shared types and helpers for the hh:mm:ss countdown timer.
// Holds the per-field time typedefs, the packed time payload, the FSM state
// enum, the field maxima, and the clamp and decrement helpers.
package cnt_time_pkg;

    localparam int unsigned SEC_W = 6;
    localparam int unsigned MIN_W = 6;
    localparam int unsigned HR_W  = 5;

    typedef logic [SEC_W-1:0] sec_t;
    typedef logic [MIN_W-1:0] min_t;
    typedef logic [HR_W-1:0]  hr_t;

    localparam sec_t MAX_SEC = SEC_W'(59);
    localparam min_t MAX_MIN = MIN_W'(59);
    localparam hr_t  MAX_HR  = HR_W'(23);

    typedef struct packed {
        hr_t  hr;
        min_t min;
        sec_t sec;
    } cd_time_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Saturate an out-of-range preset to the field maximum.
    function automatic cd_time_t clamp_time(input sec_t s, input min_t m, input hr_t h);
        cd_time_t r;
        r.sec = (s > MAX_SEC) ? MAX_SEC : s;
        r.min = (m > MAX_MIN) ? MAX_MIN : m;
        r.hr  = (h > MAX_HR)  ? MAX_HR  : h;
        return r;
    endfunction

    // True when exactly one second remains, i.e. the next decrement reaches zero.
    function automatic logic is_one_sec(input cd_time_t t);
        return (t.hr == '0) && (t.min == '0) && (t.sec == SEC_W'(1));
    endfunction

    // Subtract one second with borrow; hours saturate at zero.
    function automatic cd_time_t dec_time(input cd_time_t t);
        cd_time_t r;
        r = t;
        if (t.sec != '0) begin
            r.sec = t.sec - SEC_W'(1);
        end else begin
            r.sec = MAX_SEC;
            if (t.min != '0) begin
                r.min = t.min - MIN_W'(1);
            end else begin
                r.min = MAX_MIN;
                if (t.hr != '0) begin
                    r.hr = t.hr - HR_W'(1);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second tick generator: counts enabled cycles 0..TICK_DIV-1.
// Ports: clk, rst (async active-low), clr (sync clear, wins over en),
//        en (count enable), tick (high on the enabled terminal-count cycle).
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear, hold, or advance with wrap at terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Internal strobe consumed by the owning FSM in the same cycle.
    assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/countdown_sec_min_hr.sv
// Hours/minutes/seconds countdown timer with load, start, pause and done pulse.
// Ports: clk, rst (async active-low), load + load_sec/load_min/load_hr (preset),
//        start, pause; outputs sec/min/hr (remaining time), running, done.
// Build option: define AUTO_RELOAD_EN to reload the last preset on expiry and
// keep running instead of passing through DONE.
module countdown_sec_min_hr
    import cnt_time_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  sec_t load_sec,
    input  min_t load_min,
    input  hr_t  load_hr,
    input  logic start,
    input  logic pause,
    output sec_t sec,
    output min_t min,
    output hr_t  hr,
    output logic running,
    output logic done
);

    state_e   state_q, state_d;
    cd_time_t time_q, time_d;
    logic     done_q, done_d;
    logic     running_q;
    logic     tick;
    logic     presc_en;
    logic     presc_clr;
    logic     go;
`ifdef AUTO_RELOAD_EN
    cd_time_t preset_q, preset_d;
`endif

    // Pause gates the prescaler in the same cycle so time and phase are frozen.
    assign presc_en  = (state_q == ST_RUN) && !pause;
    assign presc_clr = load || (state_q == ST_IDLE) || (state_q == ST_DONE);
    // A simultaneous pause overrides start.
    assign go        = start && !pause;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (tick)
    );

    // Next-state, time and done-pulse logic; load overrides everything.
    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        done_d   = 1'b0;
`ifdef AUTO_RELOAD_EN
        preset_d = preset_q;
`endif
        if (load) begin
            time_d  = clamp_time(load_sec, load_min, load_hr);
            state_d = ST_IDLE;
`ifdef AUTO_RELOAD_EN
            preset_d = time_d;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        if (time_q == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (tick) begin
                        if (is_one_sec(time_q)) begin
                            done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                            time_d  = preset_q;
                            state_d = (preset_q == '0) ? ST_IDLE : ST_RUN;
`else
                            time_d  = '0;
                            state_d = ST_DONE;
`endif
                        end else begin
                            time_d = dec_time(time_q);
                        end
                    end
                end
                ST_PAUSED: begin
                    if (go) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            time_q    <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
`ifdef AUTO_RELOAD_EN
            preset_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            done_q    <= done_d;
            running_q <= (state_d == ST_RUN);
`ifdef AUTO_RELOAD_EN
            preset_q  <= preset_d;
`endif
        end
    end

    assign sec     = time_q.sec;
    assign min     = time_q.min;
    assign hr      = time_q.hr;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_sec_min_hr.sv
// Scoreboard bench for countdown_sec_min_hr (TICK_DIV = 4).
// The driver pushes expected snapshots tagged with the cycle they apply to,
// plus the cycles on which a done pulse must appear; a monitor on the falling
// edge pops and compares them and flags any done pulse that was not expected.
module tb_countdown_sec_min_hr;

    localparam int unsigned TD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [5:0] load_sec;
    logic [5:0] load_min;
    logic [4:0] load_hr;
    logic       start;
    logic       pause;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic       running;
    logic       done;

    typedef struct packed {
        int         cyc;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       run;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];
    int    done_q[$];
    int    cyc        = 0;
    int    vectors    = 0;
    int    miscompares = 0;
    exp_t  mon_e;
    string mon_nm;

    countdown_sec_min_hr #(
        .TICK_DIV (TD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_sec (load_sec),
        .load_min (load_min),
        .load_hr  (load_hr),
        .start    (start),
        .pause    (pause),
        .sec      (sec),
        .min      (min),
        .hr       (hr),
        .running  (running),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected outputs at the falling edge ofs rising edges from now.
    task automatic expect_at(input int ofs, input int h, input int m, input int s,
                             input logic run, input string nm);
        exp_t e;
        e.cyc = cyc + ofs;
        e.h   = 5'(h);
        e.m   = 6'(m);
        e.s   = 6'(s);
        e.run = run;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic expect_done(input int ofs);
        done_q.push_back(cyc + ofs);
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load     = 1'b1;
        load_hr  = 5'(h);
        load_min = 6'(m);
        load_sec = 6'(s);
        step(1);
        load     = 1'b0;
    endtask

    // Monitor: compare every snapshot due this cycle and police done pulses.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e  = exp_q.pop_front();
            mon_nm = nm_q.pop_front();
            vectors = vectors + 1;
            if (mon_e.cyc != cyc) begin
                miscompares = miscompares + 1;
                $display("FAIL %s: check for cycle %0d reached at cycle %0d", mon_nm, mon_e.cyc, cyc);
            end else if (hr !== mon_e.h || min !== mon_e.m || sec !== mon_e.s || running !== mon_e.run) begin
                miscompares = miscompares + 1;
                $display("FAIL %s: got %0d:%0d:%0d running=%0b, want %0d:%0d:%0d running=%0b",
                         mon_nm, hr, min, sec, running, mon_e.h, mon_e.m, mon_e.s, mon_e.run);
            end
        end
        if (done_q.size() > 0 && done_q[0] == cyc) begin
            void'(done_q.pop_front());
            vectors = vectors + 1;
            if (done !== 1'b1) begin
                miscompares = miscompares + 1;
                $display("FAIL done_pulse: got done=%b at cycle %0d, want 1", done, cyc);
            end
        end else if (done !== 1'b0) begin
            vectors = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL done_spurious: got done=%b at cycle %0d, want 0", done, cyc);
        end
    end

    initial begin
        rst      = 1'b0;
        load     = 1'b0;
        load_sec = '0;
        load_min = '0;
        load_hr  = '0;
        start    = 1'b0;
        pause    = 1'b0;

        step(2);
        expect_at(0, 0, 0, 0, 1'b0, "reset_hold");
        rst = 1'b1;
        step(1);
        expect_at(0, 0, 0, 0, 1'b0, "reset_release");

`ifdef AUTO_RELOAD_EN
        // 00:00:03 repeating: done every 3 decrements, never leaving RUN.
        do_load(0, 0, 3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        expect_at(0, 0, 0, 3, 1'b1, "R_entry");
        expect_at(11, 0, 0, 1, 1'b1, "R_last_sec");
        expect_done(12);
        expect_at(12, 0, 0, 3, 1'b1, "R_reload1");
        expect_done(24);
        expect_at(24, 0, 0, 3, 1'b1, "R_reload2");
        expect_at(35, 0, 0, 1, 1'b1, "R_still_running");
        expect_done(36);
        expect_at(36, 0, 0, 3, 1'b1, "R_reload3");
        step(37);
        do_load(0, 0, 0);
        expect_at(0, 0, 0, 0, 1'b0, "R_stop");
        step(2);
`else
        // A: 00:01:05, one decrement every TD cycles, done after 65.
        do_load(0, 1, 5);
        expect_at(0, 0, 1, 5, 1'b0, "A_load");
        start = 1'b1;
        step(1);
        start = 1'b0;
        expect_at(0, 0, 1, 5, 1'b1, "A_run_entry");
        expect_at(3, 0, 1, 5, 1'b1, "A_before_tick");
        expect_at(4, 0, 1, 4, 1'b1, "A_first_dec");
        expect_at(24, 0, 0, 59, 1'b1, "A_sec_borrow");
        expect_at(259, 0, 0, 1, 1'b1, "A_last_sec");
        expect_done(260);
        expect_at(260, 0, 0, 0, 1'b0, "A_done_state");
        expect_at(261, 0, 0, 0, 1'b0, "A_back_idle");
        step(262);

        // B: 01:00:00, first decrement borrows through minutes and hours.
        do_load(1, 0, 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        expect_at(0, 1, 0, 0, 1'b1, "B_entry");
        expect_at(3, 1, 0, 0, 1'b1, "B_before_tick");
        expect_at(4, 0, 59, 59, 1'b1, "B_hr_borrow");
        step(5);

        // C: 00:00:10, pause at 00:00:07 for 20 cycles, then resume to done.
        do_load(0, 0, 10);
        expect_at(0, 0, 0, 10, 1'b0, "C_load");
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(12);
        expect_at(0, 0, 0, 7, 1'b1, "C_at_7");
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        expect_at(0, 0, 0, 7, 1'b0, "C_paused");
        expect_at(20, 0, 0, 7, 1'b0, "C_paused_hold");
        step(20);
        start = 1'b1;
        step(1);
        start = 1'b0;
        expect_at(0, 0, 0, 7, 1'b1, "C_resume");
        expect_at(4, 0, 0, 6, 1'b1, "C_dec_after_resume");
        expect_done(28);
        expect_at(28, 0, 0, 0, 1'b0, "C_done_state");
        expect_at(29, 0, 0, 0, 1'b0, "C_back_idle");
        step(30);

        // D: clamping, then load and start together stays in IDLE.
        do_load(30, 63, 63);
        expect_at(0, 23, 59, 59, 1'b0, "D_clamp");
        start = 1'b1;
        do_load(0, 0, 5);
        start = 1'b0;
        expect_at(0, 0, 0, 5, 1'b0, "D_load_start");
        expect_at(1, 0, 0, 5, 1'b0, "D_still_idle");
        step(2);

        // E: reset mid-run at 00:00:03, then start with zero time.
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(8);
        expect_at(0, 0, 0, 3, 1'b1, "E_before_reset");
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        vectors = vectors + 1;
        if (hr !== 5'd0 || min !== 6'd0 || sec !== 6'd0 || running !== 1'b0 || done !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL E_async_reset: got %0d:%0d:%0d running=%0b done=%0b, want 0:0:0 running=0 done=0",
                     hr, min, sec, running, done);
        end
        step(2);
        rst = 1'b1;
        expect_at(0, 0, 0, 0, 1'b0, "E_after_release");
        start = 1'b1;
        step(1);
        start = 1'b0;
        expect_done(0);
        expect_at(0, 0, 0, 0, 1'b0, "E_zero_start_done");
        expect_at(1, 0, 0, 0, 1'b0, "E_back_idle");
        step(3);

        // F: pause with start in RUN is a pause.
        do_load(0, 0, 2);
        start = 1'b1;
        step(1);
        pause = 1'b1;
        step(1);
        start = 1'b0;
        pause = 1'b0;
        expect_at(0, 0, 0, 2, 1'b0, "F_pause_wins");
        step(3);
        expect_at(0, 0, 0, 2, 1'b0, "F_pause_holds");
        do_load(0, 0, 0);
        step(3);
`endif

        step(2);
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            miscompares = miscompares + exp_q.size() + done_q.size();
            $display("FAIL leftover: got %0d snapshots and %0d done pulses unchecked, want 0",
                     exp_q.size(), done_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
